// File: rtl/genram.sv
// genram: byte-serial, bounds-checked RAM moving 1..2**EXTRA bytes per request, little-endian.
// Define GENRAM_WRITE_EN to build the write path; without it the block is a ROM and writes fault.
module genram #(
    parameter int unsigned AW      = 6,
    parameter int unsigned EXTRA   = 4,
    parameter string       ROMFILE = ""
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [AW:0]             addr,
    input  logic [EXTRA-1:0]        extra,
    input  logic [AW:0]             lower_bound,
    input  logic [AW:0]             upper_bound,
    input  logic [(2**EXTRA)*8-1:0] wdata,
    output logic [(2**EXTRA)*8-1:0] rdata,
    output logic                    rsp_valid,
    output logic                    error
);
    localparam int unsigned ADDR_W = AW + 1;
    localparam int unsigned END_W  = AW + 2;
    localparam int unsigned DATA_W = (2 ** EXTRA) * 8;

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [EXTRA-1:0]    extra_q;
    logic [EXTRA-1:0]    cnt_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                error_q;

    logic [7:0]          mem [2**ADDR_W];

    logic                accept;
    logic                last;
    logic                fault;
    logic                write_fault;
    logic                do_read;
    logic [END_W-1:0]    end_addr;
    logic [ADDR_W-1:0]   byte_addr;

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rdata     = rdata_q;
    assign error     = error_q;
    assign accept    = req_valid && req_ready;
    assign last      = (cnt_q == extra_q);
    assign byte_addr = addr_q + ADDR_W'(cnt_q);

    // One extra bit on the end address so a request running past the top of the array is caught.
    assign end_addr = {1'b0, addr} + END_W'(extra);
    assign fault    = (addr < lower_bound) || (end_addr > {1'b0, upper_bound}) || write_fault;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = fault ? StResp : StBusy;
            StBusy:  if (last) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            extra_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= addr;
                extra_q <= extra;
                cnt_q   <= '0;
                rdata_q <= '0;
                error_q <= fault;
            end else if (state_q == StBusy) begin
                if (do_read) rdata_q[{cnt_q, 3'b000} +: 8] <= mem[byte_addr];
                if (!last) cnt_q <= cnt_q + EXTRA'(1);
            end
        end
    end

`ifdef GENRAM_WRITE_EN
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;

    assign write_fault = 1'b0;
    assign do_read     = !write_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_q <= 1'b0;
            wdata_q <= '0;
        end else if (accept) begin
            write_q <= req_write;
            wdata_q <= wdata;
        end
    end

    // Array contents are deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (state_q == StBusy && write_q) mem[byte_addr] <= wdata_q[{cnt_q, 3'b000} +: 8];
    end
`else
    logic unused_wdata;

    assign write_fault = req_write;
    assign do_read     = 1'b1;
    assign unused_wdata = ^wdata;
`endif

endmodule
